up_state_ctrl: RTL and testbench

//  uP-level sequencer and memory-port owner in front of Core.

---
 rtl/up_state_ctrl_pkg.sv | 20 ++
 rtl/mux2.sv | 13 +
 rtl/up_state_ctrl_boot_copier.sv | 43 ++++
 rtl/up_state_ctrl.sv | 118 +++++++++++
 tb/tb_up_state_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/up_state_ctrl_pkg.sv
// Shared definitions for the uP sequencer: state encoding and datapath width.
package up_state_ctrl_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSING = 2'd2,
    ST_PAUSED  = 2'd3
  } upState_t;

  // Bundled memory-port request: address, write data, write enable.
  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
    logic              wr;
  } memReq_t;

endpackage

// File: rtl/mux2.sv
// Generic 2:1 mux cell; selects i_b when i_sel is high.
module Mux2 #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sel,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/up_state_ctrl_boot_copier.sv
// Boot image copier: hands out ready, counts accepted words, flags the last one.
module up_state_ctrl_boot_copier
  import up_state_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_WORDS = 16'h8000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_active,
  input  logic              i_bootValid,
  output logic              o_bootReady,
  output logic [WORD_W-1:0] o_bootCnt,
  output logic              o_accept,
  output logic              o_done
);

  localparam logic [WORD_W-1:0] LAST_IDX = WORD_W'(BOOT_WORDS - 1);

  logic              readyReg;
  logic [WORD_W-1:0] bootCnt;
  logic              isLast;

  assign isLast   = (bootCnt == LAST_IDX);
  assign o_accept = i_bootValid & readyReg;
  assign o_done   = o_accept & isLast;

  // Ready comes up one clock after reset release and drops for good on the last word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      readyReg <= 1'b0;
      bootCnt  <= '0;
    end else begin
      if (o_done)        readyReg <= 1'b0;
      else if (i_active) readyReg <= 1'b1;

      if (o_accept && !isLast) bootCnt <= bootCnt + 1'b1;
    end
  end

  assign o_bootReady = readyReg;
  assign o_bootCnt   = bootCnt;

endmodule

// File: rtl/up_state_ctrl.sv
// uP sequencer: boots memory from an image stream, releases Core, runs pause/resume
// handshakes and lends the memory port to debug while paused.
//  state      | meaning
//  ST_BOOT    | copying boot image into memory, Core held off
//  ST_RUN     | Core running and owning the memory port
//  ST_PAUSING | pause requested from Core, waiting for its acknowledge
//  ST_PAUSED  | Core paused, debug may take the memory port
module up_state_ctrl
  import up_state_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_WORDS = 16'h8000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WORD_W-1:0] i_bootData,
  input  logic              i_bootValid,
  output logic              o_bootReady,
  input  logic              i_pauseReq,
  input  logic              i_resumeReq,
  output logic              o_smIsBooted,
  output logic              o_smStartPause,
  input  logic              i_smNowPaused,
  input  logic              i_coreHlt,
  input  logic [WORD_W-1:0] i_coreAddr,
  input  logic [WORD_W-1:0] i_coreDataOut,
  input  logic              i_coreWr,
  output logic [WORD_W-1:0] o_coreDataIn,
  input  logic              i_dbgReq,
  input  logic [WORD_W-1:0] i_dbgAddr,
  input  logic [WORD_W-1:0] i_dbgData,
  input  logic              i_dbgWr,
  output logic [WORD_W-1:0] o_dbgData,
  output logic              o_dbgGrant,
  output logic [WORD_W-1:0] o_memAddr,
  output logic [WORD_W-1:0] o_memDataOut,
  output logic              o_memWr,
  input  logic [WORD_W-1:0] i_memDataIn,
  output logic              o_paused
);

  upState_t          state, stateNext;
  logic              isBoot;
  logic              bootAccept;
  logic              bootDone;
  logic [WORD_W-1:0] bootCnt;
  memReq_t           bootReq, coreReq, dbgReq, runReq, memReq;

  up_state_ctrl_boot_copier #(.BOOT_WORDS(BOOT_WORDS)) uBootCopier (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_active    (isBoot),
    .i_bootValid (i_bootValid),
    .o_bootReady (o_bootReady),
    .o_bootCnt   (bootCnt),
    .o_accept    (bootAccept),
    .o_done      (bootDone)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_BOOT;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext      = state;
    o_smIsBooted   = 1'b1;
    o_smStartPause = 1'b0;
    o_paused       = 1'b0;
    o_dbgGrant     = 1'b0;
    unique case (state)
      ST_BOOT: begin
        o_smIsBooted = 1'b0;
        if (bootDone) stateNext = ST_RUN;
      end
      ST_RUN: begin
        if (i_pauseReq || i_coreHlt) stateNext = ST_PAUSING;
      end
      ST_PAUSING: begin
        o_smStartPause = 1'b1;
        if (i_smNowPaused) stateNext = ST_PAUSED;
      end
      ST_PAUSED: begin
        // Held high throughout: Core's paused flag is a delayed copy of this line.
        o_smStartPause = 1'b1;
        o_paused       = 1'b1;
        o_dbgGrant     = i_dbgReq;
        if (i_resumeReq && !i_pauseReq) stateNext = ST_RUN;
      end
      default: stateNext = ST_BOOT;
    endcase
  end

  assign isBoot  = (state == ST_BOOT);
  assign bootReq = '{addr: bootCnt,    data: i_bootData,    wr: bootAccept};
  assign coreReq = '{addr: i_coreAddr, data: i_coreDataOut, wr: i_coreWr};
  assign dbgReq  = '{addr: i_dbgAddr,  data: i_dbgData,     wr: i_dbgWr};

  Mux2 #(.W($bits(memReq_t))) uDbgMux (
    .i_a   (coreReq),
    .i_b   (dbgReq),
    .i_sel (o_dbgGrant),
    .o_y   (runReq)
  );

  Mux2 #(.W($bits(memReq_t))) uBootMux (
    .i_a   (runReq),
    .i_b   (bootReq),
    .i_sel (isBoot),
    .o_y   (memReq)
  );

  assign o_memAddr    = memReq.addr;
  assign o_memDataOut = memReq.data;
  assign o_memWr      = memReq.wr;
  assign o_coreDataIn = i_memDataIn;
  assign o_dbgData    = i_memDataIn;

endmodule

// File: tb/tb_up_state_ctrl.sv
// Self-checking bench for up_state_ctrl with a 4-word boot image and a write scoreboard.
module tb_up_state_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bootData = '0;
  logic        bootValid = 1'b0;
  logic        bootReady;
  logic        pauseReq = 1'b0;
  logic        resumeReq = 1'b0;
  logic        smIsBooted;
  logic        smStartPause;
  logic        smNowPaused = 1'b0;
  logic        coreHlt = 1'b0;
  logic [15:0] coreAddr = '0;
  logic [15:0] coreDataOut = '0;
  logic        coreWr = 1'b0;
  logic [15:0] coreDataIn;
  logic        dbgReq = 1'b0;
  logic [15:0] dbgAddr = '0;
  logic [15:0] dbgDataIn = '0;
  logic        dbgWr = 1'b0;
  logic [15:0] dbgDataOut;
  logic        dbgGrant;
  logic [15:0] memAddr;
  logic [15:0] memDataOut;
  logic        memWr;
  logic [15:0] memDataIn;
  logic        paused;

  logic [15:0] mem [0:255];
  logic [31:0] expWrites [$];
  int          testsRun = 0;
  int          testsFailed = 0;

  always #5 clk = ~clk;

  up_state_ctrl #(.BOOT_WORDS(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_bootData     (bootData),
    .i_bootValid    (bootValid),
    .o_bootReady    (bootReady),
    .i_pauseReq     (pauseReq),
    .i_resumeReq    (resumeReq),
    .o_smIsBooted   (smIsBooted),
    .o_smStartPause (smStartPause),
    .i_smNowPaused  (smNowPaused),
    .i_coreHlt      (coreHlt),
    .i_coreAddr     (coreAddr),
    .i_coreDataOut  (coreDataOut),
    .i_coreWr       (coreWr),
    .o_coreDataIn   (coreDataIn),
    .i_dbgReq       (dbgReq),
    .i_dbgAddr      (dbgAddr),
    .i_dbgData      (dbgDataIn),
    .i_dbgWr        (dbgWr),
    .o_dbgData      (dbgDataOut),
    .o_dbgGrant     (dbgGrant),
    .o_memAddr      (memAddr),
    .o_memDataOut   (memDataOut),
    .o_memWr        (memWr),
    .i_memDataIn    (memDataIn),
    .o_paused       (paused)
  );

  // Memory model with combinational read
  assign memDataIn = mem[memAddr[7:0]];
  always @(posedge clk) if (memWr) mem[memAddr[7:0]] <= memDataOut;

  // Scoreboard: every write cycle seen at the port must match the next expected write
  always @(negedge clk) begin
    if (memWr) begin
      testsRun++;
      if (expWrites.size() == 0) begin
        testsFailed++;
        $display("FAIL sb_unexpected_write: got addr=%h data=%h, expected no write", memAddr, memDataOut);
      end else begin
        logic [31:0] e;
        e = expWrites.pop_front();
        if ({memAddr, memDataOut} !== e) begin
          testsFailed++;
          $display("FAIL sb_write: got addr=%h data=%h, expected addr=%h data=%h",
                   memAddr, memDataOut, e[31:16], e[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic boot_word(input logic [15:0] expAddr, input logic [15:0] data);
    int budget;
    budget = 0;
    while (bootReady !== 1'b1 && budget < 10) begin
      tick();
      budget++;
    end
    testsRun++;
    if (bootReady !== 1'b1) begin
      testsFailed++;
      $display("FAIL boot_ready_timeout: got ready=%b, expected 1", bootReady);
    end
    bootData  = data;
    bootValid = 1'b1;
    expWrites.push_back({expAddr, data});
    #1;
    testsRun++;
    if (memAddr !== expAddr || memWr !== 1'b1) begin
      testsFailed++;
      $display("FAIL boot_addr: got addr=%h wr=%b, expected addr=%h wr=1", memAddr, memWr, expAddr);
    end
    tick();
    bootValid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    testsRun++;
    if (smIsBooted !== 0 || bootReady !== 0 || memWr !== 0 || memAddr !== 16'h0 ||
        paused !== 0 || smStartPause !== 0 || dbgGrant !== 0) begin
      testsFailed++;
      $display("FAIL reset_outputs: got booted=%b ready=%b wr=%b addr=%h paused=%b sp=%b grant=%b, expected all 0",
               smIsBooted, bootReady, memWr, memAddr, paused, smStartPause, dbgGrant);
    end
    tick();
    rst = 1'b0;
    testsRun++;
    if (bootReady !== 1'b0) begin
      testsFailed++;
      $display("FAIL ready_before_clock: got %b, expected 0", bootReady);
    end
    tick();
    testsRun++;
    if (bootReady !== 1'b1) begin
      testsFailed++;
      $display("FAIL ready_after_clock: got %b, expected 1", bootReady);
    end
  endtask

  task automatic test_boot();
    logic [15:0] img [4];
    img = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (smIsBooted !== 1'b0) begin
        testsFailed++;
        $display("FAIL booted_early: word %0d got %b, expected 0", i, smIsBooted);
      end
      boot_word(16'(i), img[i]);
      if (i < 3) tick();
    end
    testsRun++;
    if (smIsBooted !== 1'b1 || bootReady !== 1'b0) begin
      testsFailed++;
      $display("FAIL boot_done: got booted=%b ready=%b, expected booted=1 ready=0", smIsBooted, bootReady);
    end
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (mem[i] !== img[i]) begin
        testsFailed++;
        $display("FAIL boot_mem: addr %0d got %h, expected %h", i, mem[i], img[i]);
      end
    end
  endtask

  task automatic test_pause();
    pauseReq = 1'b1;
    tick();
    pauseReq = 1'b0;
    testsRun++;
    if (smStartPause !== 1'b1 || paused !== 1'b0) begin
      testsFailed++;
      $display("FAIL pausing: got sp=%b paused=%b, expected sp=1 paused=0", smStartPause, paused);
    end
    tick();
    testsRun++;
    if (smStartPause !== 1'b1 || paused !== 1'b0) begin
      testsFailed++;
      $display("FAIL pausing_hold: got sp=%b paused=%b, expected sp=1 paused=0", smStartPause, paused);
    end
    smNowPaused = 1'b1;
    tick();
    tick();
    testsRun++;
    if (smStartPause !== 1'b1 || paused !== 1'b1 || smIsBooted !== 1'b1) begin
      testsFailed++;
      $display("FAIL paused: got sp=%b paused=%b booted=%b, expected 1 1 1", smStartPause, paused, smIsBooted);
    end
  endtask

  task automatic test_debug();
    coreAddr  = 16'h0003;
    dbgReq    = 1'b1;
    dbgWr     = 1'b1;
    dbgAddr   = 16'h0010;
    dbgDataIn = 16'hBEEF;
    expWrites.push_back({16'h0010, 16'hBEEF});
    #1;
    testsRun++;
    if (dbgGrant !== 1'b1 || memAddr !== 16'h0010 || memWr !== 1'b1) begin
      testsFailed++;
      $display("FAIL dbg_write: got grant=%b addr=%h wr=%b, expected 1 0010 1", dbgGrant, memAddr, memWr);
    end
    tick();
    dbgWr = 1'b0;
    #1;
    testsRun++;
    if (dbgDataOut !== 16'hBEEF || memAddr !== 16'h0010) begin
      testsFailed++;
      $display("FAIL dbg_read: got data=%h addr=%h, expected BEEF 0010", dbgDataOut, memAddr);
    end
    tick();
    dbgReq = 1'b0;
    #1;
    testsRun++;
    if (dbgGrant !== 1'b0 || memAddr !== 16'h0003) begin
      testsFailed++;
      $display("FAIL dbg_release: got grant=%b addr=%h, expected 0 0003", dbgGrant, memAddr);
    end
  endtask

  task automatic test_resume_hlt();
    pauseReq  = 1'b1;
    resumeReq = 1'b1;
    tick();
    resumeReq = 1'b0;
    pauseReq  = 1'b0;
    testsRun++;
    if (paused !== 1'b1) begin
      testsFailed++;
      $display("FAIL resume_blocked: got paused=%b, expected 1", paused);
    end
    resumeReq = 1'b1;
    tick();
    resumeReq   = 1'b0;
    smNowPaused = 1'b0;
    testsRun++;
    if (paused !== 1'b0 || smStartPause !== 1'b0 || smIsBooted !== 1'b1) begin
      testsFailed++;
      $display("FAIL resume: got paused=%b sp=%b booted=%b, expected 0 0 1", paused, smStartPause, smIsBooted);
    end
    coreHlt = 1'b1;
    tick();
    coreHlt = 1'b0;
    testsRun++;
    if (smStartPause !== 1'b1 || paused !== 1'b0) begin
      testsFailed++;
      $display("FAIL hlt_pausing: got sp=%b paused=%b, expected 1 0", smStartPause, paused);
    end
    smNowPaused = 1'b1;
    tick();
    testsRun++;
    if (paused !== 1'b1) begin
      testsFailed++;
      $display("FAIL hlt_paused: got paused=%b, expected 1", paused);
    end
    resumeReq = 1'b1;
    tick();
    resumeReq   = 1'b0;
    smNowPaused = 1'b0;
    testsRun++;
    if (smStartPause !== 1'b0 || paused !== 1'b0) begin
      testsFailed++;
      $display("FAIL hlt_resume: got sp=%b paused=%b, expected 0 0", smStartPause, paused);
    end
    // Simultaneous pause sources: lands in PAUSING, not straight into PAUSED
    pauseReq = 1'b1;
    coreHlt  = 1'b1;
    tick();
    pauseReq = 1'b0;
    coreHlt  = 1'b0;
    tick();
    testsRun++;
    if (smStartPause !== 1'b1 || paused !== 1'b0) begin
      testsFailed++;
      $display("FAIL both_sources: got sp=%b paused=%b, expected 1 0", smStartPause, paused);
    end
    smNowPaused = 1'b1;
    tick();
    resumeReq = 1'b1;
    tick();
    resumeReq   = 1'b0;
    smNowPaused = 1'b0;
    testsRun++;
    if (paused !== 1'b0 || smStartPause !== 1'b0) begin
      testsFailed++;
      $display("FAIL both_resume: got paused=%b sp=%b, expected 0 0", paused, smStartPause);
    end
  endtask

  task automatic test_dbg_in_run();
    dbgReq    = 1'b1;
    dbgWr     = 1'b1;
    dbgAddr   = 16'h0020;
    dbgDataIn = 16'hDEAD;
    coreAddr  = 16'h0005;
    coreWr    = 1'b0;
    #1;
    testsRun++;
    if (dbgGrant !== 1'b0 || memAddr !== 16'h0005 || memWr !== 1'b0) begin
      testsFailed++;
      $display("FAIL run_dbg_ignored: got grant=%b addr=%h wr=%b, expected 0 0005 0", dbgGrant, memAddr, memWr);
    end
    coreWr      = 1'b1;
    coreDataOut = 16'hCAFE;
    expWrites.push_back({16'h0005, 16'hCAFE});
    #1;
    testsRun++;
    if (memWr !== 1'b1 || memDataOut !== 16'hCAFE) begin
      testsFailed++;
      $display("FAIL run_core_write: got wr=%b data=%h, expected 1 CAFE", memWr, memDataOut);
    end
    tick();
    coreWr = 1'b0;
    dbgReq = 1'b0;
    dbgWr  = 1'b0;
    #1;
    testsRun++;
    if (coreDataIn !== 16'hCAFE) begin
      testsFailed++;
      $display("FAIL run_core_read: got %h, expected CAFE", coreDataIn);
    end
  endtask

  task automatic test_reset_mid_boot();
    rst = 1'b1;
    #1;
    testsRun++;
    if (smIsBooted !== 1'b0) begin
      testsFailed++;
      $display("FAIL rst_booted: got %b, expected 0", smIsBooted);
    end
    tick();
    rst = 1'b0;
    tick();
    boot_word(16'h0000, 16'hA000);
    boot_word(16'h0001, 16'hA001);
    // Reset lands while a third word is offered: that write must not happen
    bootData  = 16'h7777;
    bootValid = 1'b1;
    rst       = 1'b1;
    #1;
    testsRun++;
    if (memWr !== 1'b0 || memAddr !== 16'h0000 || bootReady !== 1'b0) begin
      testsFailed++;
      $display("FAIL rst_drop: got wr=%b addr=%h ready=%b, expected 0 0000 0", memWr, memAddr, bootReady);
    end
    tick();
    rst = 1'b0;
    #1;
    testsRun++;
    if (memWr !== 1'b0) begin
      testsFailed++;
      $display("FAIL rst_no_early_accept: got wr=%b, expected 0", memWr);
    end
    tick();
    bootValid = 1'b0;
    boot_word(16'h0000, 16'h5555);
    boot_word(16'h0001, 16'h5556);
    boot_word(16'h0002, 16'h5557);
    testsRun++;
    if (smIsBooted !== 1'b0) begin
      testsFailed++;
      $display("FAIL reboot_early: got %b, expected 0", smIsBooted);
    end
    boot_word(16'h0003, 16'h5558);
    testsRun++;
    if (smIsBooted !== 1'b1 || bootReady !== 1'b0 || mem[0] !== 16'h5555) begin
      testsFailed++;
      $display("FAIL reboot_done: got booted=%b ready=%b mem0=%h, expected 1 0 5555",
               smIsBooted, bootReady, mem[0]);
    end
    // Boot valid after boot completes must not write anything
    bootValid = 1'b1;
    tick();
    tick();
    bootValid = 1'b0;
  endtask

  task automatic test_scoreboard_drain();
    tick();
    testsRun++;
    if (expWrites.size() != 0) begin
      testsFailed++;
      $display("FAIL sb_drain: got %0d writes pending, expected 0", expWrites.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_boot();
    test_pause();
    test_debug();
    test_resume_hlt();
    test_dbg_in_run();
    test_reset_mid_boot();
    test_scoreboard_drain();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
